tpu_tile_sequencer: RTL and testbench
=====================================

# tpu_tile_sequencer

Parametrised control engine for the TPU core: on `start` it pops one weight tile from the weight FIFO, reloads the systolic array, streams `num_vecs` activation words from the unified buffer through an input skew line, and deskews the array's partial-sum outputs into aligned result vectors with a valid strobe. It sits between the unified buffer, the weight FIFO and the systolic array. It replaces the fixed counters and the standalone data-setup logic with one handshaked, length-programmable sequencer that signals completion.

## Interface
- `ADDRESSSIZE`, 10, unified-buffer address width
- `DATA_BW`, 8, activation lane width
- `MATRIX_SIZE`, 8, activation lanes per word; SRAM word = `DATA_BW*MATRIX_SIZE`
- `NUM_PE_ROWS`, 8, result columns
- `PARTIAL_SUM_BW`, 19, result lane width
- `LEN_BW`, 8, width of `num_vecs`
- `ARRAY_LAT`, 15, cycles from lane 0 of DIN at the array to column 0 of `result_in`

Ports:
- `clk`  in  1  clock; single clock domain
- `rstn`  in  1  asynchronous, active-low reset
- `start`  in  1  launch pulse, sampled only in IDLE
- `abort`  in  1  synchronous cancel
- `base_addr`  in  ADDRESSSIZE  first activation address
- `num_vecs`  in  LEN_BW  number of activation vectors
- `fifo_empty`  in  1  weight FIFO empty
- `fifo_read_enable`  out  1  one-cycle FIFO pop
- `we_rl`  out  1  one-cycle weight reload to the array
- `sram_address`  out  ADDRESSSIZE  UB read address; 1-cycle read latency
- `sram_rdata`  in  DATA_BW*MATRIX_SIZE  UB read data
- `din`  out  DATA_BW*MATRIX_SIZE  skewed activations to the array
- `result_in`  in  PARTIAL_SUM_BW*NUM_PE_ROWS  skewed array output
- `result_data`  out  PARTIAL_SUM_BW*NUM_PE_ROWS  aligned result vector
- `result_valid`  out  1  `result_data` is valid this cycle
- `busy`  out  1  high whenever the FSM is not in IDLE
- `done`  out  1  one-cycle completion pulse
- `perf_cycles`  out  32  busy-cycle count (see Configuration)

## Operation
- FSM states: IDLE, WPOP, WLOAD, STREAM, DRAIN, DONE.
- IDLE, `start` and `num_vecs`≠0: go to WPOP. IDLE, `start` and `num_vecs`=0: go to DONE. There is no FIFO or SRAM activity in the zero-length case.
- WPOP: waits while `fifo_empty` is high, with no timeout. When `fifo_empty` is low, asserts `fifo_read_enable` for 1 cycle and goes to WLOAD.
- WLOAD: asserts `we_rl` for 1 cycle, then goes to STREAM.
- STREAM: drives `sram_address` = `base_addr`+k for k = 0..N-1, one address per cycle. Addresses wrap modulo 2^ADDRESSSIZE. Each issue pushes a valid tag into the pipeline. After N issues, goes to DRAIN.
- DRAIN: holds until the last tag emerges as `result_valid`, then goes to DONE.
- DONE: `done` high for 1 cycle, then goes to IDLE.
- Input skew: lane i of `sram_rdata` is delayed i registers; lane 0 has no delay. A lane carrying no valid tag outputs zero.
- Output deskew: column j of `result_in` is delayed NUM_PE_ROWS-1-j registers.
- `start` is ignored while `busy` is high.
- `abort`, in any non-IDLE state, returns the FSM to IDLE on the next cycle. It clears all valid tags and produces no `done` and no further `result_valid`.
- Reset values: every output is 0; all skew registers, tags and counters are cleared.

## Timing
- Cycle 0: `start` is high in IDLE and the FIFO is non-empty.
- Cycle 1: `fifo_read_enable`=1. Cycle 2: `we_rl`=1.
- Vector k: address issued at cycle 3+k, `sram_rdata` at cycle 4+k, `din` lane i at cycle 4+k+i.
- Result for vector k: `result_valid` at cycle 4+k+ARRAY_LAT+NUM_PE_ROWS-1.
- `done` at cycle N+ARRAY_LAT+NUM_PE_ROWS+3. Defaults with N=4 give cycle 30.
- Each cycle WPOP stalls on an empty FIFO shifts all of the above by 1.
- `num_vecs`=0: `done` at cycle 1.

## Configuration
- `TPU_SEQ_PERF_CNT_EN` defined: `perf_cycles` clears on an accepted `start`, increments every cycle `busy` is high, and holds its value after `done` or `abort`.
- `TPU_SEQ_PERF_CNT_EN` undefined: `perf_cycles` is tied to 0 and the counter logic is not built.

## Structure
- Package `tpu_seq_pkg` holds:
  - the state enum;
  - the derived latency constants (SRAM_LAT=1, DESKEW_LAT=NUM_PE_ROWS-1);
  - the tag-pipeline depth (1+ARRAY_LAT+DESKEW_LAT).
- Sub-module `skew_delay_line`, parameters LANES, LANE_BW and ASCENDING:
  - lane i is delayed i stages when ASCENDING, LANES-1-i stages otherwise;
  - instantiated twice, once for input skew and once for output deskew.

## Test plan
- Single tile: base=0x010, N=4, FIFO non-empty. Expect one `fifo_read_enable` at cycle 1, `we_rl` at cycle 2, addresses 0x010–0x013 at cycles 3–6, `result_valid` at cycles 26–29, `done` at cycle 30.
- Address wrap: base=0x3FE, N=4. Expect addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Empty FIFO: `fifo_empty` held high for 5 cycles after `start`. Expect `fifo_read_enable` at cycle 6 and `done` at cycle 35.
- Zero length: N=0. Expect `done` at cycle 1, with no pop, no `we_rl` and no `result_valid`.
- Abort: `abort` at cycle 10 with N=8. Expect IDLE at cycle 11, no `result_valid`, no `done`; then `start` is accepted again.
- Skew and deskew check, using an identity-delay array model:
  - input lane i = 0x10+i;
  - expect `din` lane i to go nonzero at cycle 4+i;
  - expect `result_data` columns aligned in a single `result_valid` cycle;
  - with `TPU_SEQ_PERF_CNT_EN` defined, expect `perf_cycles`=30.

Source files
------------

// File: rtl/tpu_seq_pkg.sv
// rtl/tpu_seq_pkg.sv - state encoding and latency constants shared by the tile sequencer
package tpu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WPOP,
        S_WLOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    localparam int SRAM_LAT = 1;

    function automatic int deskew_lat(input int num_pe_rows);
        return num_pe_rows - 1;
    endfunction

    // A tag lives from SRAM issue until the aligned result leaves the deskew line.
    function automatic int tag_depth(input int array_lat, input int num_pe_rows);
        return SRAM_LAT + array_lat + deskew_lat(num_pe_rows);
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - per-lane staircase delay, ascending or descending depth
module skew_delay_line #(
    parameter int LANES     = 8,
    parameter int LANE_BW   = 8,
    parameter bit ASCENDING = 1'b1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_clr,
    input  logic [LANES*LANE_BW-1:0] i_data,
    output logic [LANES*LANE_BW-1:0] o_data
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int D = ASCENDING ? i : (LANES - 1 - i);
        if (D == 0) begin : g_pass
            assign o_data[i*LANE_BW +: LANE_BW] = i_data[i*LANE_BW +: LANE_BW];
        end else begin : g_dly
            logic [LANE_BW-1:0] r_stage [D];
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int s = 0; s < D; s++) r_stage[s] <= '0;
                end else if (i_clr) begin
                    for (int s = 0; s < D; s++) r_stage[s] <= '0;
                end else begin
                    r_stage[0] <= i_data[i*LANE_BW +: LANE_BW];
                    for (int s = 1; s < D; s++) r_stage[s] <= r_stage[s-1];
                end
            end
            assign o_data[i*LANE_BW +: LANE_BW] = r_stage[D-1];
        end
    end

endmodule

// File: rtl/tpu_tile_sequencer.sv
// rtl/tpu_tile_sequencer.sv - weight-pop/reload/stream/drain sequencer; TPU_SEQ_PERF_CNT_EN builds the busy-cycle counter
module tpu_tile_sequencer
    import tpu_seq_pkg::*;
#(
    parameter int ADDRESSSIZE    = 10,
    parameter int DATA_BW        = 8,
    parameter int MATRIX_SIZE    = 8,
    parameter int NUM_PE_ROWS    = 8,
    parameter int PARTIAL_SUM_BW = 19,
    parameter int LEN_BW         = 8,
    parameter int ARRAY_LAT      = 15
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [ADDRESSSIZE-1:0]                base_addr,
    input  logic [LEN_BW-1:0]                     num_vecs,
    input  logic                                  fifo_empty,
    output logic                                  fifo_read_enable,
    output logic                                  we_rl,
    output logic [ADDRESSSIZE-1:0]                sram_address,
    input  logic [DATA_BW*MATRIX_SIZE-1:0]        sram_rdata,
    output logic [DATA_BW*MATRIX_SIZE-1:0]        din,
    input  logic [PARTIAL_SUM_BW*NUM_PE_ROWS-1:0] result_in,
    output logic [PARTIAL_SUM_BW*NUM_PE_ROWS-1:0] result_data,
    output logic                                  result_valid,
    output logic                                  busy,
    output logic                                  done,
    output logic [31:0]                           perf_cycles
);

    localparam int TAG_DEPTH = tag_depth(ARRAY_LAT, NUM_PE_ROWS);

    seq_state_t                          r_state;
    seq_state_t                          w_next;
    logic [ADDRESSSIZE-1:0]              r_base;
    logic [LEN_BW-1:0]                   r_len;
    logic [LEN_BW-1:0]                   r_cnt;
    logic [TAG_DEPTH-1:0]                r_tag;
    logic                                w_abort;
    logic                                w_accept;
    logic                                w_issue;
    logic                                w_last_tag;
    logic [DATA_BW*MATRIX_SIZE-1:0]      w_rdata_gated;
    logic [PARTIAL_SUM_BW*NUM_PE_ROWS-1:0] w_deskewed;

    assign w_abort    = abort && (r_state != S_IDLE);
    assign w_accept   = start && (r_state == S_IDLE);
    assign w_issue    = (r_state == S_STREAM);
    assign w_last_tag = r_tag[TAG_DEPTH-1] && (r_tag[TAG_DEPTH-2:0] == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        fifo_read_enable = 1'b0;
        we_rl            = 1'b0;
        done             = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = (num_vecs != '0) ? S_WPOP : S_DONE;
            end
            S_WPOP: begin
                if (!fifo_empty) begin
                    fifo_read_enable = 1'b1;
                    w_next           = S_WLOAD;
                end
            end
            S_WLOAD: begin
                we_rl  = 1'b1;
                w_next = S_STREAM;
            end
            S_STREAM: begin
                if (r_cnt == r_len - LEN_BW'(1)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_last_tag) w_next = S_DONE;
            end
            S_DONE: begin
                done   = !abort;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_tag  <= '0;
        end else begin
            if (w_accept) begin
                r_base <= base_addr;
                r_len  <= num_vecs;
                r_cnt  <= '0;
            end else if (w_issue) begin
                r_cnt <= r_cnt + LEN_BW'(1);
            end
            if (w_abort) r_tag <= '0;
            else         r_tag <= {r_tag[TAG_DEPTH-2:0], w_issue};
        end
    end

    assign sram_address = w_issue ? (r_base + ADDRESSSIZE'(r_cnt)) : '0;
    assign busy         = (r_state != S_IDLE);
    assign result_valid = r_tag[TAG_DEPTH-1] && !w_abort;
    assign result_data  = result_valid ? w_deskewed : '0;

    // Untagged read data is zeroed before skewing so idle lanes stay quiet.
    assign w_rdata_gated = r_tag[0] ? sram_rdata : '0;

    skew_delay_line #(
        .LANES     (MATRIX_SIZE),
        .LANE_BW   (DATA_BW),
        .ASCENDING (1'b1)
    ) u_in_skew (
        .clk    (clk),
        .rstn   (rstn),
        .i_clr  (w_abort),
        .i_data (w_rdata_gated),
        .o_data (din)
    );

    skew_delay_line #(
        .LANES     (NUM_PE_ROWS),
        .LANE_BW   (PARTIAL_SUM_BW),
        .ASCENDING (1'b0)
    ) u_out_deskew (
        .clk    (clk),
        .rstn   (rstn),
        .i_clr  (w_abort),
        .i_data (result_in),
        .o_data (w_deskewed)
    );

`ifdef TPU_SEQ_PERF_CNT_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                   r_perf <= '0;
        else if (w_accept)           r_perf <= '0;
        else if (r_state != S_IDLE)  r_perf <= r_perf + 32'd1;
    end

    assign perf_cycles = r_perf;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// tb/tb_tpu_tile_sequencer.sv - randomized tile runs against a cycle-formula reference model
module tb_tpu_tile_sequencer;

    localparam int ADDRESSSIZE    = 10;
    localparam int DATA_BW        = 8;
    localparam int MATRIX_SIZE    = 8;
    localparam int NUM_PE_ROWS    = 8;
    localparam int PARTIAL_SUM_BW = 19;
    localparam int LEN_BW         = 8;
    localparam int ARRAY_LAT      = 15;
    localparam int WORD_W         = DATA_BW * MATRIX_SIZE;
    localparam int RES_W          = PARTIAL_SUM_BW * NUM_PE_ROWS;
    localparam int RESULT_OFS     = 4 + ARRAY_LAT + NUM_PE_ROWS - 1;

    logic                   clk;
    logic                   rstn;
    logic                   start;
    logic                   abort;
    logic [ADDRESSSIZE-1:0] base_addr;
    logic [LEN_BW-1:0]      num_vecs;
    logic                   fifo_empty;
    logic                   fifo_read_enable;
    logic                   we_rl;
    logic [ADDRESSSIZE-1:0] sram_address;
    logic [WORD_W-1:0]      sram_rdata;
    logic [WORD_W-1:0]      din;
    logic [RES_W-1:0]       result_in;
    logic [RES_W-1:0]       result_data;
    logic                   result_valid;
    logic                   busy;
    logic                   done;
    logic [31:0]            perf_cycles;

    logic [WORD_W-1:0] mem [1<<ADDRESSSIZE];
    int n_checks = 0;
    int n_pass   = 0;

    tpu_tile_sequencer dut (
        .clk              (clk),
        .rstn             (rstn),
        .start            (start),
        .abort            (abort),
        .base_addr        (base_addr),
        .num_vecs         (num_vecs),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .we_rl            (we_rl),
        .sram_address     (sram_address),
        .sram_rdata       (sram_rdata),
        .din              (din),
        .result_in        (result_in),
        .result_data      (result_data),
        .result_valid     (result_valid),
        .busy             (busy),
        .done             (done),
        .perf_cycles      (perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    endtask

    // Identity array: result column j carries activation lane j, zero-extended.
    function automatic logic [RES_W-1:0] widen(input logic [WORD_W-1:0] w);
        logic [RES_W-1:0] r;
        r = '0;
        for (int j = 0; j < NUM_PE_ROWS; j++)
            r[j*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = PARTIAL_SUM_BW'(w[j*DATA_BW +: DATA_BW]);
        return r;
    endfunction

    function automatic int perf_exp(input int busy_cycles);
`ifdef TPU_SEQ_PERF_CNT_EN
        return busy_cycles;
`else
        return 0 * busy_cycles;
`endif
    endfunction

    // Cycle 0 is the cycle in which start is presented; abort_at < 0 means no abort.
    task automatic run_tile(input logic [ADDRESSSIZE-1:0] b, input int n, input int stall, input int abort_at);
        int done_c, last_c, k;
        logic [ADDRESSSIZE-1:0] prev_addr, a;
        logic [WORD_W-1:0] hist [ARRAY_LAT];
        logic [WORD_W-1:0] exp_din, word;
        logic post, live;
        done_c    = (n == 0) ? 1 : n + ARRAY_LAT + NUM_PE_ROWS + 3 + stall;
        last_c    = (abort_at >= 0) ? abort_at : done_c;
        prev_addr = '0;
        for (int h = 0; h < ARRAY_LAT; h++) hist[h] = '0;
        for (int c = 0; c <= last_c + 3; c++) begin
            start      = (c == 0) || (c < last_c && $urandom_range(0, 1) == 1);
            num_vecs   = (c == 0) ? LEN_BW'(n) : LEN_BW'($urandom);
            base_addr  = (c == 0) ? b : ADDRESSSIZE'($urandom);
            fifo_empty = (c >= 1 && c <= stall) ? 1'b1 :
                         (c > stall + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            abort      = (c == abort_at);
            sram_rdata = mem[prev_addr];
            result_in  = widen(hist[ARRAY_LAT-1]);
            @(negedge clk);
            post = (abort_at >= 0) && (c > abort_at);
            live = !post && (n > 0);
            check_eq("busy", busy, !post && c >= 1 && c <= last_c);
            check_eq("fifo_read_enable", fifo_read_enable, live && c == 1 + stall);
            check_eq("we_rl", we_rl, live && c == 2 + stall);
            check_eq("done", done, abort_at < 0 && c == done_c);
            k = c - 3 - stall;
            if (live && k >= 0 && k < n) check_eq("sram_address", sram_address, ADDRESSSIZE'(b + k));
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                k = c - 4 - stall - i;
                a = ADDRESSSIZE'(b + k);
                word = mem[a];
                exp_din[i*DATA_BW +: DATA_BW] = (live && k >= 0 && k < n) ? word[i*DATA_BW +: DATA_BW] : '0;
            end
            check_eq("din", din, exp_din);
            k = c - RESULT_OFS - stall;
            check_eq("result_valid", result_valid, live && k >= 0 && k < n);
            if (live && k >= 0 && k < n) begin
                a = ADDRESSSIZE'(b + k);
                check_eq("result_data", result_data, widen(mem[a]));
            end
            if (c == last_c + 3) check_eq("perf_cycles", perf_cycles, perf_exp(last_c));
            prev_addr = sram_address;
            for (int h = ARRAY_LAT - 1; h > 0; h--) hist[h] = hist[h-1];
            hist[0] = din;
            @(posedge clk);
            #1;
        end
        start      = 1'b0;
        abort      = 1'b0;
        fifo_empty = 1'b0;
    endtask

    initial begin
        rstn       = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        base_addr  = '0;
        num_vecs   = '0;
        fifo_empty = 1'b0;
        for (int a = 0; a < (1 << ADDRESSSIZE); a++)
            for (int i = 0; i < MATRIX_SIZE; i++)
                mem[a][i*DATA_BW +: DATA_BW] = DATA_BW'($urandom_range(1, 255));
        for (int i = 0; i < MATRIX_SIZE; i++)
            mem[10'h010][i*DATA_BW +: DATA_BW] = DATA_BW'(8'h10 + i);
        sram_rdata = mem[5];
        result_in  = '1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset busy", busy, 1'b0);
        check_eq("reset fifo_read_enable", fifo_read_enable, 1'b0);
        check_eq("reset we_rl", we_rl, 1'b0);
        check_eq("reset done", done, 1'b0);
        check_eq("reset result_valid", result_valid, 1'b0);
        check_eq("reset sram_address", sram_address, '0);
        check_eq("reset din", din, '0);
        check_eq("reset result_data", result_data, '0);
        check_eq("reset perf_cycles", perf_cycles, '0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        run_tile(10'h010, 4, 0, -1);
        run_tile(10'h3FE, 4, 0, -1);
        run_tile(ADDRESSSIZE'($urandom), 4, 5, -1);
        run_tile(ADDRESSSIZE'($urandom), 0, 0, -1);
        run_tile(ADDRESSSIZE'($urandom), 8, 0, 10);
        run_tile(10'h010, 4, 0, -1);
        run_tile(ADDRESSSIZE'($urandom), 255, 1, -1);
        for (int r = 0; r < 12; r++)
            run_tile(ADDRESSSIZE'($urandom), $urandom_range(1, 20), $urandom_range(0, 3),
                     (r % 4 == 3) ? $urandom_range(1, 20) : -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
